// File: rtl/fpsr_pkg.sv
// Shared constants for the game-time base and the game-state controller.
// Holds the default timing parameters, the professor-visit nibble and the
// minutes width, plus the 9-bit to 8-bit saturation helper.
package fpsr_pkg;

    localparam int unsigned CLK_HZ_DEF      = 100000000;
    localparam int unsigned MAX_TIME_DEF    = 120;
    localparam int unsigned PENALTY_MIN_DEF = 5;
    localparam int unsigned MIN_W           = 8;
    localparam int unsigned SEC_W           = 6;
    localparam logic [3:0]  PROF_NIBBLE     = 4'hF;

    // Clamp a one-bit-wider sum to the minutes range.
    function automatic logic [MIN_W-1:0] sat_min(input logic [MIN_W:0] sum);
        return sum[MIN_W] ? {MIN_W{1'b1}} : sum[MIN_W-1:0];
    endfunction

endpackage

// File: rtl/game_clock_prescaler.sv
// Board-clock divider producing a one-cycle sec_tick at terminal count.
// Build option: GAME_CLOCK_FAST_EN shortens the terminal count to
// CLK_HZ/FAST_DIV-1 for demo and simulation runs.
// Ports:
//   Clk, Reset   clock, asynchronous active-high reset
//   clear        synchronous clear of the count (wins over en)
//   en           count advances when high; count is kept when low
//   sec_tick     combinational strobe, high in the terminal-count cycle
module game_clock_prescaler #(
    parameter int unsigned CLK_HZ   = 100000000,
    parameter int unsigned FAST_DIV = 1000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic en,
    output logic sec_tick
);

`ifdef GAME_CLOCK_FAST_EN
    localparam int unsigned TC = ((CLK_HZ / FAST_DIV) > 0) ? (CLK_HZ / FAST_DIV) - 1 : 0;
`else
    localparam int unsigned TC = (CLK_HZ > 0) ? CLK_HZ - 1 : 0;
`endif
    localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;

    // Count register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_n;
        end
    end

    // Next count and terminal-count strobe.
    always_comb begin
        cnt_n    = cnt;
        sec_tick = 1'b0;
        if (clear) begin
            cnt_n = '0;
        end else if (en) begin
            if (cnt == CNT_W'(TC)) begin
                cnt_n    = '0;
                sec_tick = 1'b1;
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/game_clock.sv
// Game-time base for the game-state controller: scales the board clock to
// game minutes, applies penalties, flags time-up and raises the sticky
// professor-visit request on minutes ending in xF.
// Build option: GAME_CLOCK_FAST_EN (selects the fast prescaler count).
// Ports:
//   Clk, Reset   clock, asynchronous active-high reset
//   clear        synchronous clear of all state (highest priority)
//   run, hold    time advances when run=1 and hold=0
//   penalty      strobe adding PENALTY_MIN minutes (applied even while paused)
//   prof_ack     clears prof_req
//   minutes      elapsed game minutes, saturating at 255
//   sec_cnt      real seconds within the current game minute
//   min_tick     pulse aligned with a clock-advanced minutes value
//   time_up      minutes >= MAX_TIME
//   prof_req     sticky professor-visit request
module game_clock
    import fpsr_pkg::*;
#(
    parameter int unsigned CLK_HZ      = CLK_HZ_DEF,
    parameter int unsigned SEC_PER_MIN = 1,
    parameter int unsigned MAX_TIME    = MAX_TIME_DEF,
    parameter int unsigned PENALTY_MIN = PENALTY_MIN_DEF,
    parameter int unsigned FAST_DIV    = 1000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic             run,
    input  logic             hold,
    input  logic             penalty,
    input  logic             prof_ack,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] sec_cnt,
    output logic             min_tick,
    output logic             time_up,
    output logic             prof_req
);

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_PER_MIN - 1);

    logic             sec_tick;
    logic             advance_en;
    logic [MIN_W-1:0] minutes_n;
    logic [SEC_W-1:0] sec_cnt_n;
    logic             min_tick_n;
    logic             time_up_n;
    logic             prof_req_n;
    logic             min_adv;
    logic             prof_set;
    logic [MIN_W:0]   pen_add;

    assign advance_en = run & ~hold;

    game_clock_prescaler #(
        .CLK_HZ   (CLK_HZ),
        .FAST_DIV (FAST_DIV)
    ) u_prescaler (
        .Clk      (Clk),
        .Reset    (Reset),
        .clear    (clear),
        .en       (advance_en),
        .sec_tick (sec_tick)
    );

    // Output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            minutes  <= '0;
            sec_cnt  <= '0;
            min_tick <= 1'b0;
            time_up  <= 1'b0;
            prof_req <= 1'b0;
        end else begin
            minutes  <= minutes_n;
            sec_cnt  <= sec_cnt_n;
            min_tick <= min_tick_n;
            time_up  <= time_up_n;
            prof_req <= prof_req_n;
        end
    end

    // Seconds, minutes, penalty, time-up and professor-request next state.
    always_comb begin
        minutes_n  = minutes;
        sec_cnt_n  = sec_cnt;
        min_tick_n = 1'b0;
        time_up_n  = time_up;
        prof_req_n = prof_req;
        min_adv    = 1'b0;
        prof_set   = 1'b0;
        pen_add    = penalty ? (MIN_W+1)'(PENALTY_MIN) : '0;

        if (clear) begin
            minutes_n  = '0;
            sec_cnt_n  = '0;
            time_up_n  = 1'b0;
            prof_req_n = 1'b0;
        end else begin
            // sec_tick only fires while advancing, so no extra gating here.
            if (sec_tick) begin
                if (sec_cnt == SEC_LAST) begin
                    sec_cnt_n = '0;
                    min_adv   = 1'b1;
                end else begin
                    sec_cnt_n = sec_cnt + SEC_W'(1);
                end
            end

            // A clock advance at 255 is dropped entirely; penalty alone cannot
            // move a saturated value either.
            if (min_adv && (minutes != {MIN_W{1'b1}})) begin
                minutes_n  = sat_min({1'b0, minutes} + (MIN_W+1)'(1) + pen_add);
                min_tick_n = 1'b1;
                prof_set   = (minutes_n[3:0] == PROF_NIBBLE);
            end else if (penalty) begin
                minutes_n = sat_min({1'b0, minutes} + pen_add);
            end

            time_up_n  = (32'(minutes_n) >= MAX_TIME);
            prof_req_n = prof_set | (prof_req & ~prof_ack);
        end
    end

endmodule

// File: tb/tb_game_clock.sv
module tb_game_clock;

    localparam int unsigned HZ  = 10;
    localparam int unsigned SPM = 2;
    localparam int unsigned CPM = HZ * SPM;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       clear;
    logic       run;
    logic       hold;
    logic       penalty;
    logic       prof_ack;
    logic [7:0] minutes;
    logic [5:0] sec_cnt;
    logic       min_tick;
    logic       time_up;
    logic       prof_req;

    int total = 0;
    int bad   = 0;

    // Reference model: e = advancing cycles since clear; a minute boundary is
    // every CPM advancing cycles, seconds are e/HZ modulo SPM.
    int e;
    int mm;
    bit mtk;
    bit mtu;
    bit mpr;

    wire [16:0] obs = {minutes, sec_cnt, min_tick, time_up, prof_req};

    game_clock #(
        .CLK_HZ      (HZ),
        .SEC_PER_MIN (SPM),
        .MAX_TIME    (120),
        .PENALTY_MIN (5),
        .FAST_DIV    (1000)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .clear    (clear),
        .run      (run),
        .hold     (hold),
        .penalty  (penalty),
        .prof_ack (prof_ack),
        .minutes  (minutes),
        .sec_cnt  (sec_cnt),
        .min_tick (min_tick),
        .time_up  (time_up),
        .prof_req (prof_req)
    );

    always #5 Clk = ~Clk;

    function automatic void model_reset();
        e   = 0;
        mm  = 0;
        mtk = 1'b0;
        mtu = 1'b0;
        mpr = 1'b0;
    endfunction

    function automatic void model_step();
        bit adv;
        int nm;
        if (clear) begin
            model_reset();
            return;
        end
        adv = 1'b0;
        if (run && !hold) begin
            e++;
            adv = ((e % CPM) == 0);
        end
        if (adv && mm != 255) begin
            nm  = mm + 1 + (penalty ? 5 : 0);
            if (nm > 255) nm = 255;
            mtk = 1'b1;
            if ((nm % 16) == 15) mpr = 1'b1;
            else if (prof_ack) mpr = 1'b0;
        end else begin
            nm  = mm + (penalty ? 5 : 0);
            if (nm > 255) nm = 255;
            mtk = 1'b0;
            if (prof_ack) mpr = 1'b0;
        end
        mm  = nm;
        mtu = (mm >= 120);
    endfunction

    function automatic logic [16:0] exp_vec();
        return {8'(mm), 6'((e / HZ) % SPM), mtk, mtu, mpr};
    endfunction

    // One clock: inputs are stable at the edge, outputs sampled on the falling edge.
    task automatic step();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; clear = 0; run = 0; hold = 0; penalty = 0; prof_ack = 0;
        model_reset();
        repeat (2) @(negedge Clk);
        total++;
        if (obs !== 17'd0) begin
            bad++; $display("FAIL reset: got %h want %h", obs, 17'd0);
        end
        Reset = 1'b0;
    endtask

    task automatic test_first_minute();
        int ticks = 0;
        int tick_at = -1;
        run = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL first_min c%0d: got %h want %h", i, obs, exp_vec());
            end
            if (min_tick) begin ticks++; tick_at = i; end
        end
        total++;
        if ({minutes, sec_cnt, min_tick} !== {8'd1, 6'd0, 1'b1}) begin
            bad++; $display("FAIL first_min_end: got m=%0d s=%0d t=%b want m=1 s=0 t=1",
                            minutes, sec_cnt, min_tick);
        end
        total++;
        if (ticks != 1 || tick_at != 20) begin
            bad++; $display("FAIL first_min_ticks: got n=%0d at=%0d want n=1 at=20", ticks, tick_at);
        end
    endtask

    task automatic test_prof_req();
        int n = 0;
        while (minutes != 8'd15 && n < 400) begin
            step(); n++;
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL prof_run: got %h want %h", obs, exp_vec());
            end
        end
        total++;
        if ({minutes, min_tick, prof_req} !== {8'd15, 1'b1, 1'b1}) begin
            bad++; $display("FAIL prof_set: got m=%0d t=%b p=%b want m=15 t=1 p=1",
                            minutes, min_tick, prof_req);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            total++;
            if (prof_req !== 1'b1 || obs !== exp_vec()) begin
                bad++; $display("FAIL prof_sticky: got %h want %h", obs, exp_vec());
            end
        end
        prof_ack = 1'b1;
        step();
        prof_ack = 1'b0;
        total++;
        if (prof_req !== 1'b0 || obs !== exp_vec()) begin
            bad++; $display("FAIL prof_ack: got p=%b want p=0", prof_req);
        end
    endtask

    task automatic test_hold();
        int n = 0;
        int rem;
        logic [16:0] snap;
        do_clear();
        run = 1'b1;
        while (minutes != 8'd10 && n < 300) begin
            step(); n++;
        end
        total++;
        if (obs !== exp_vec()) begin
            bad++; $display("FAIL hold_reach: got %h want %h", obs, exp_vec());
        end
        repeat ($urandom_range(1, 18)) step();
        snap = obs;
        hold = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            total++;
            if (obs !== snap || obs !== exp_vec()) begin
                bad++; $display("FAIL hold_frozen: got %h want %h", obs, snap);
            end
        end
        hold = 1'b0;
        rem = CPM - (e % CPM);
        n = 0;
        do begin
            step(); n++;
        end while (!min_tick && n < 40);
        total++;
        if (n != rem || obs !== exp_vec()) begin
            bad++; $display("FAIL hold_resume: got %0d cycles want %0d", n, rem);
        end
    endtask

    task automatic test_penalty_sat();
        int n = 0;
        logic pr_before;
        do_clear();
        hold = 1'b1; penalty = 1'b1;
        repeat (23) step();
        penalty = 1'b0; hold = 1'b0;
        while (minutes != 8'd117 && n < 60) begin
            step(); n++;
        end
        pr_before = prof_req;
        penalty = 1'b1;
        step();
        penalty = 1'b0;
        total++;
        if ({minutes, time_up, prof_req} !== {8'd122, 1'b1, pr_before} || obs !== exp_vec()) begin
            bad++; $display("FAIL pen_117: got m=%0d tu=%b p=%b want m=122 tu=1 p=%b",
                            minutes, time_up, prof_req, pr_before);
        end
        hold = 1'b1; penalty = 1'b1;
        repeat (26) step();
        penalty = 1'b0; hold = 1'b0;
        n = 0;
        while (minutes != 8'd253 && n < 40) begin
            step(); n++;
        end
        penalty = 1'b1;
        step();
        penalty = 1'b0;
        total++;
        if (minutes !== 8'd255 || obs !== exp_vec()) begin
            bad++; $display("FAIL pen_sat: got m=%0d want m=255", minutes);
        end
        for (int i = 0; i < 60; i++) begin
            step();
            total++;
            if (min_tick !== 1'b0 || minutes !== 8'd255 || obs !== exp_vec()) begin
                bad++; $display("FAIL sat_hold: got m=%0d t=%b want m=255 t=0", minutes, min_tick);
            end
        end
    endtask

    task automatic test_coincident();
        do_clear();
        hold = 1'b1; penalty = 1'b1;
        step();
        penalty = 1'b0; hold = 1'b0;
        repeat (4 * CPM + CPM - 1) step();
        total++;
        if (obs !== exp_vec() || minutes !== 8'd9) begin
            bad++; $display("FAIL coin_pre: got %h want %h", obs, exp_vec());
        end
        penalty = 1'b1;
        step();
        penalty = 1'b0;
        total++;
        if ({minutes, min_tick, prof_req} !== {8'd15, 1'b1, 1'b1} || obs !== exp_vec()) begin
            bad++; $display("FAIL coin_pen: got m=%0d t=%b p=%b want m=15 t=1 p=1",
                            minutes, min_tick, prof_req);
        end
        do_clear();
        hold = 1'b1; penalty = 1'b1;
        repeat (6) step();
        penalty = 1'b0; hold = 1'b0;
        repeat (CPM - 1) step();
        prof_ack = 1'b1;
        step();
        prof_ack = 1'b0;
        total++;
        if ({minutes, min_tick, prof_req} !== {8'd31, 1'b1, 1'b1} || obs !== exp_vec()) begin
            bad++; $display("FAIL coin_ack: got m=%0d t=%b p=%b want m=31 t=1 p=1",
                            minutes, min_tick, prof_req);
        end
    endtask

    task automatic test_clear();
        do_clear();
        hold = 1'b1; penalty = 1'b1;
        repeat (2) step();
        penalty = 1'b0; hold = 1'b0;
        repeat (5 * CPM) step();
        hold = 1'b1; penalty = 1'b1;
        repeat (5) step();
        penalty = 1'b0; hold = 1'b0;
        repeat ($urandom_range(1, 15)) step();
        total++;
        if ({minutes, prof_req} !== {8'd40, 1'b1} || obs !== exp_vec()) begin
            bad++; $display("FAIL clr_pre: got m=%0d p=%b want m=40 p=1", minutes, prof_req);
        end
        clear = 1'b1; penalty = 1'b1;
        step();
        clear = 1'b0; penalty = 1'b0;
        total++;
        if (obs !== 17'd0) begin
            bad++; $display("FAIL clr_zero: got %h want 0", obs);
        end
        repeat (CPM + HZ + 3) step();
        total++;
        if ({minutes, sec_cnt} !== {8'd1, 6'd1} || obs !== exp_vec()) begin
            bad++; $display("FAIL rst_pre: got m=%0d s=%0d want m=1 s=1", minutes, sec_cnt);
        end
        #2 Reset = 1'b1;
        #1;
        model_reset();
        total++;
        if (obs !== 17'd0) begin
            bad++; $display("FAIL async_rst: got %h want 0", obs);
        end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_random();
        do_clear();
        for (int i = 0; i < 3000; i++) begin
            run      = ($urandom % 8) != 0;
            hold     = ($urandom % 6) == 0;
            penalty  = ($urandom % 40) == 0;
            prof_ack = ($urandom % 5) == 0;
            clear    = ($urandom % 400) == 0;
            step();
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL random c%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        clear = 0; run = 0; hold = 0; penalty = 0; prof_ack = 0;
    endtask

    initial begin
        test_reset();
        test_first_minute();
        test_prof_req();
        test_hold();
        test_penalty_sat();
        test_coincident();
        test_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
